// File: rtl/marquee_pkg.sv
// Shared constants and types for the eight-LED running-light controller.
// Mode/direction encodings, reset pattern and speed-to-divisor mapping.
package marquee_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'd0,
    MODE_ROT_L = 2'd1,
    MODE_ROT_R = 2'd2,
    MODE_PING  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam logic [7:0] LED_RST = 8'h01;

  function automatic logic [3:0] div(input logic [1:0] speed);
    return 4'd8 >> speed;
  endfunction

endpackage

// File: rtl/marquee_key_press.sv
// Falling-edge press detector for one debounced active-low key.
// A key must be seen released once after reset before a press counts.
module key_press (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  logic key_q, key_d;
  logic arm_q, arm_d;

  always_comb begin
    key_d = key;
    arm_d = arm_q | key;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= 1'b1;
      arm_q <= 1'b0;
    end else begin
      key_q <= key_d;
      arm_q <= arm_d;
    end
  end

  assign press = arm_q & key_q & ~key;

endmodule

// File: rtl/marquee_ctrl.sv
// Running-light controller: mode/speed keys, prescaled step tick,
// and the one-hot LED pattern FSM. All outputs registered.
module marquee_ctrl
  import marquee_pkg::*;
#(
  parameter int TICK_BASE = 2_500_000,
  parameter int LED_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_mode,
  input  logic             key_speed,
  output logic [LED_W-1:0] led,
  output logic [1:0]       mode,
  output logic [1:0]       speed,
  output logic             step
);

  localparam int PW = (TICK_BASE > 1) ? $clog2(TICK_BASE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_BASE - 1);

  logic mode_press, speed_press;

  key_press u_key_mode (
    .clk   (clk),
    .rst   (rst),
    .key   (key_mode),
    .press (mode_press)
  );

  key_press u_key_speed (
    .clk   (clk),
    .rst   (rst),
    .key   (key_speed),
    .press (speed_press)
  );

  logic [LED_W-1:0] led_q, led_d;
  mode_e            mode_q, mode_d;
  logic [1:0]       speed_q, speed_d;
  logic             step_q, step_d;
  dir_e             dir_q, dir_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [2:0]       scnt_q, scnt_d;

  logic       base_tick, step_hit;
  logic [3:0] dv;

  always_comb begin
    dv        = div(speed_q);
    base_tick = (presc_q == PMAX);
    step_hit  = base_tick && (scnt_q == 3'(dv - 4'd1));
  end

  always_comb begin
    led_d   = led_q;
    mode_d  = mode_q;
    speed_d = speed_q;
    step_d  = 1'b0;
    dir_d   = dir_q;
    presc_d = base_tick ? '0 : presc_q + PW'(1);
    scnt_d  = scnt_q;

    if (base_tick)
      scnt_d = step_hit ? 3'd0 : scnt_q + 3'd1;

    if (step_hit) begin
      step_d = 1'b1;
      unique case (mode_q)
        MODE_HOLD: ;
        MODE_ROT_L: led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
        MODE_ROT_R: led_d = {led_q[0], led_q[LED_W-1:1]};
        MODE_PING: begin
          if (dir_q == DIR_LEFT) begin
            if (led_q[LED_W-1]) begin
              led_d = '0;
              led_d[LED_W-2] = 1'b1;
              dir_d = DIR_RIGHT;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              led_d = '0;
              led_d[1] = 1'b1;
              dir_d = DIR_LEFT;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
      endcase
    end

    // A speed press restarts the step count and swallows a coincident step.
    if (speed_press) begin
      speed_d = speed_q + 2'd1;
      scnt_d  = 3'd0;
      step_d  = 1'b0;
      led_d   = led_q;
      dir_d   = dir_q;
    end

    if (mode_press) begin
      mode_d  = mode_e'(mode_q + 2'd1);
      led_d   = LED_W'(LED_RST);
      dir_d   = DIR_LEFT;
      presc_d = '0;
      scnt_d  = 3'd0;
      step_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= LED_W'(LED_RST);
      mode_q  <= MODE_HOLD;
      speed_q <= 2'd0;
      step_q  <= 1'b0;
      dir_q   <= DIR_LEFT;
      presc_q <= '0;
      scnt_q  <= 3'd0;
    end else begin
      led_q   <= led_d;
      mode_q  <= mode_d;
      speed_q <= speed_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      presc_q <= presc_d;
      scnt_q  <= scnt_d;
    end
  end

  assign led   = led_q;
  assign mode  = mode_q;
  assign speed = speed_q;
  assign step  = step_q;

endmodule
